// File: rtl/sd_tx_gigmac2.sv
// rtl/sd_tx_gigmac2.sv - GMII transmit MAC: preamble/SFD framing, zero padding, CRC-32 FCS, IPG
// The FSM decides each edge what the registered GMII outputs carry in the following cycle.
module sd_tx_gigmac2 #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_LEN      = 12,
  parameter int MIN_FRAME    = 60
) (
  input  logic       clk,
  input  logic       reset,
  output logic       gmii_tx_dv,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  input  logic       txg_srdy,
  output logic       txg_drdy,
  input  logic [1:0] txg_code,
  input  logic [7:0] txg_data,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [1:0]  PCC_DATA   = 2'd0;
  localparam logic [1:0]  PCC_SOP    = 2'd1;
  localparam logic [1:0]  PCC_EOP    = 2'd2;
  localparam logic [1:0]  PCC_BADEOP = 2'd3;
  localparam logic [7:0]  GMII_PRE   = 8'h55;
  localparam logic [7:0]  GMII_SFD   = 8'hD5;
  localparam logic [3:0]  PRE_LEN    = 4'(PREAMBLE_LEN);
  localparam logic [5:0]  IPG_LAST   = 6'(IPG_LEN - 1);
  localparam logic [10:0] MIN_LEN    = 11'(MIN_FRAME);

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_PREAMBLE = 8'b0000_0010,
    S_SFD      = 8'b0000_0100,
    S_PAYLOAD  = 8'b0000_1000,
    S_PAD      = 8'b0001_0000,
    S_FCS      = 8'b0010_0000,
    S_DRAIN    = 8'b0100_0000,
    S_IPG      = 8'b1000_0000
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [5:0]  ipg_cnt_q, ipg_cnt_d;
  logic [1:0]  fcs_cnt_q, fcs_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        bad_q, bad_d;
  logic        occ_q, occ_d;
  logic [9:0]  hold_q, hold_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic [7:0]  txd_q, txd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ip_srdy;
  logic        ip_drdy;
  logic [1:0]  ip_code;
  logic [7:0]  ip_data;
  logic [10:0] byte_inc;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed), one byte LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign ip_srdy = occ_q;
  assign ip_code = hold_q[9:8];
  assign ip_data = hold_q[7:0];

  always_comb begin
    occ_d    = occ_q;
    hold_d   = hold_q;
    txg_drdy = !occ_q || ip_drdy;
    if (txg_srdy && txg_drdy) begin
      occ_d  = 1'b1;
      hold_d = {txg_code, txg_data};
    end else if (ip_drdy) begin
      occ_d  = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    ipg_cnt_d  = ipg_cnt_q;
    fcs_cnt_d  = fcs_cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    bad_d      = bad_q;
    ip_drdy    = 1'b0;
    dv_d       = 1'b0;
    er_d       = 1'b0;
    txd_d      = txd_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    byte_inc   = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    // FCS is ~crc; a bad frame sends the uncomplemented register instead.
    fcs_byte   = crc_q[{fcs_cnt_q, 3'b000} +: 8] ^ (bad_q ? 8'h00 : 8'hFF);

    unique case (state_q)
      S_IDLE: begin
        if (ip_srdy) begin
          if (ip_code == PCC_SOP) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 4'd1;
            dv_d      = 1'b1;
            txd_d     = GMII_PRE;
          end else begin
            ip_drdy   = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        dv_d = 1'b1;
        if (pre_cnt_q < PRE_LEN) begin
          txd_d     = GMII_PRE;
          pre_cnt_d = pre_cnt_q + 4'd1;
        end else begin
          txd_d      = GMII_SFD;
          state_d    = S_SFD;
          byte_cnt_d = 11'd0;
          crc_d      = 32'hFFFF_FFFF;
          bad_d      = 1'b0;
        end
      end
      S_SFD, S_PAYLOAD: begin
        dv_d = 1'b1;
        if (!ip_srdy) begin
          er_d    = 1'b1;
          txd_d   = 8'h00;
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (ip_code == PCC_SOP && state_q == S_PAYLOAD) begin
          // The SOP stays in the holding stage and opens the next frame after the gap.
          er_d      = 1'b1;
          txd_d     = 8'h00;
          err_d     = 1'b1;
          state_d   = S_IPG;
          ipg_cnt_d = 6'd0;
        end else begin
          ip_drdy    = 1'b1;
          txd_d      = ip_data;
          crc_d      = crc32_byte(crc_q, ip_data);
          byte_cnt_d = byte_inc;
          state_d    = S_PAYLOAD;
          if (ip_code == PCC_EOP || ip_code == PCC_BADEOP) begin
            bad_d     = (ip_code == PCC_BADEOP);
            fcs_cnt_d = 2'd0;
            state_d   = (byte_inc < MIN_LEN) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        dv_d       = 1'b1;
        txd_d      = 8'h00;
        crc_d      = crc32_byte(crc_q, 8'h00);
        byte_cnt_d = byte_inc;
        if (byte_inc >= MIN_LEN) begin
          fcs_cnt_d = 2'd0;
          state_d   = S_FCS;
        end
      end
      S_FCS: begin
        dv_d      = 1'b1;
        er_d      = bad_q;
        txd_d     = fcs_byte;
        fcs_cnt_d = fcs_cnt_q + 2'd1;
        if (fcs_cnt_q == 2'd3) begin
          done_d    = !bad_q;
          err_d     = bad_q;
          state_d   = S_IPG;
          ipg_cnt_d = 6'd0;
        end
      end
      S_DRAIN: begin
        ip_drdy = ip_srdy;
        if (ip_srdy && (ip_code == PCC_EOP || ip_code == PCC_BADEOP)) begin
          state_d   = S_IPG;
          ipg_cnt_d = 6'd0;
        end
      end
      S_IPG: begin
        if (ipg_cnt_q == IPG_LAST) begin
          state_d = S_IDLE;
        end else begin
          ipg_cnt_d = ipg_cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= 4'd0;
      ipg_cnt_q  <= 6'd0;
      fcs_cnt_q  <= 2'd0;
      byte_cnt_q <= 11'd0;
      crc_q      <= 32'hFFFF_FFFF;
      bad_q      <= 1'b0;
      occ_q      <= 1'b0;
      hold_q     <= 10'd0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      txd_q      <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      ipg_cnt_q  <= ipg_cnt_d;
      fcs_cnt_q  <= fcs_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      bad_q      <= bad_d;
      occ_q      <= occ_d;
      hold_q     <= hold_d;
      dv_q       <= dv_d;
      er_q       <= er_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign gmii_tx_dv = dv_q;
  assign gmii_tx_er = er_q;
  assign gmii_txd   = txd_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;

endmodule

// File: tb/tb_sd_tx_gigmac2.sv
// tb/tb_sd_tx_gigmac2.sv - scoreboard bench for sd_tx_gigmac2 across three parameter sets
module tb_sd_tx_gigmac2;

  localparam logic [1:0] PCC_DATA   = 2'd0;
  localparam logic [1:0] PCC_SOP    = 2'd1;
  localparam logic [1:0] PCC_EOP    = 2'd2;
  localparam logic [1:0] PCC_BADEOP = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         sel = 0;
  logic       srdy = 1'b0;
  logic [1:0] code = 2'd0;
  logic [7:0] data = 8'd0;

  logic       drdy_a [3];
  logic       dv_a   [3];
  logic       er_a   [3];
  logic [7:0] txd_a  [3];
  logic       done_a [3];
  logic       err_a  [3];

  logic       drdy_m, dv_m, er_m, done_m, err_m;
  logic [7:0] txd_m;

  int n_vec = 0;
  int n_bad = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  pay[$];
  bit          sb_on = 1'b1;
  bit          prev_dv = 1'b0;
  int          gap_cnt = 0, cur_len = 0, last_gap = 0, last_len = 0;
  int          done_cnt = 0, err_cnt = 0, er_cnt = 0;

  always #5 clk = ~clk;

  sd_tx_gigmac2 u_dut0 (
    .clk(clk), .reset(reset),
    .gmii_tx_dv(dv_a[0]), .gmii_tx_er(er_a[0]), .gmii_txd(txd_a[0]),
    .txg_srdy(srdy && sel == 0), .txg_drdy(drdy_a[0]), .txg_code(code), .txg_data(data),
    .tx_done(done_a[0]), .tx_err(err_a[0])
  );

  sd_tx_gigmac2 #(.PREAMBLE_LEN(7), .IPG_LEN(12), .MIN_FRAME(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .gmii_tx_dv(dv_a[1]), .gmii_tx_er(er_a[1]), .gmii_txd(txd_a[1]),
    .txg_srdy(srdy && sel == 1), .txg_drdy(drdy_a[1]), .txg_code(code), .txg_data(data),
    .tx_done(done_a[1]), .tx_err(err_a[1])
  );

  sd_tx_gigmac2 #(.PREAMBLE_LEN(3), .IPG_LEN(5), .MIN_FRAME(60)) u_dut2 (
    .clk(clk), .reset(reset),
    .gmii_tx_dv(dv_a[2]), .gmii_tx_er(er_a[2]), .gmii_txd(txd_a[2]),
    .txg_srdy(srdy && sel == 2), .txg_drdy(drdy_a[2]), .txg_code(code), .txg_data(data),
    .tx_done(done_a[2]), .tx_err(err_a[2])
  );

  assign drdy_m = drdy_a[sel];
  assign dv_m   = dv_a[sel];
  assign er_m   = er_a[sel];
  assign txd_m  = txd_a[sel];
  assign done_m = done_a[sel];
  assign err_m  = err_a[sel];

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Non-reflected shift register fed LSB-first; its bit reversal equals the reflected CRC.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (dv_m) begin
      if (!prev_dv) begin
        last_gap = gap_cnt;
        cur_len  = 0;
        rx_q.delete();
      end
      cur_len++;
      rx_q.push_back(txd_m);
      if (er_m)   er_cnt++;
      if (done_m) done_cnt++;
      if (err_m)  err_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) expect_eq("unexpected_dv", dv_m, 1'b0);
        else expect_eq("gmii_word", {done_m, err_m, er_m, txd_m}, exp_q.pop_front());
      end
    end else begin
      if (prev_dv) begin
        last_len = cur_len;
        gap_cnt  = 0;
      end
      gap_cnt++;
      if (sb_on && (done_m || err_m || er_m)) expect_eq("idle_status", {done_m, err_m, er_m}, 3'b000);
    end
    prev_dv = dv_m;
  end

  task automatic push_head(input int pre, input int nbytes);
    for (int i = 0; i < pre; i++) exp_q.push_back({3'b000, 8'h55});
    exp_q.push_back({3'b000, 8'hD5});
    for (int i = 0; i < nbytes; i++) exp_q.push_back({3'b000, pay[i]});
  endtask

  task automatic push_frame(input int pre, input int minf, input bit bad);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFF_FFFF;
    push_head(pre, pay.size());
    for (int i = 0; i < pay.size(); i++) c = crc_upd(c, pay[i]);
    for (int i = pay.size(); i < minf; i++) begin
      exp_q.push_back(11'h000);
      c = crc_upd(c, 8'h00);
    end
    fcs = ~rev32(c);
    if (bad) fcs = ~fcs;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({(i == 3) && !bad, (i == 3) && bad, bad, fcs[8*i +: 8]});
  endtask

  task automatic put(input logic [1:0] c, input logic [7:0] d);
    int t;
    t = 0;
    srdy = 1'b1;
    code = c;
    data = d;
    #1;
    while (!drdy_m && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 2000) expect_eq("drdy_timeout", drdy_m, 1'b1);
    @(negedge clk);
  endtask

  task automatic send(input bit bad, input int drop_after, input bit no_eop);
    int n;
    logic [1:0] c;
    n = pay.size();
    for (int i = 0; i < n; i++) begin
      if (drop_after > 0 && i == drop_after) begin
        srdy = 1'b0;
        repeat (4) @(negedge clk);
      end
      if (i == 0) c = PCC_SOP;
      else if (i == n - 1 && !no_eop) c = bad ? PCC_BADEOP : PCC_EOP;
      else c = PCC_DATA;
      put(c, pay[i]);
    end
    srdy = 1'b0;
  endtask

  task automatic wait_empty(input int settle);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    expect_eq("sb_drained", exp_q.size(), 0);
    repeat (settle) @(negedge clk);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    int d0, e0, r0;
    string s;

    repeat (3) @(negedge clk);
    expect_eq("reset_outputs", {dv_m, er_m, txd_m, done_m, err_m}, 12'h000);
    expect_eq("reset_drdy", drdy_m, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // 64-byte frame, no padding
    rand_pay(64);
    d0 = done_cnt;
    push_frame(7, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("len_64", last_len, 76);
    expect_eq("done_64", done_cnt - d0, 1);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < rx_q.size(); i++) c = crc_upd(c, rx_q[i]);
    expect_eq("residue", rev32(c), 32'hDEBB_20E3);
    repeat (15) @(negedge clk);

    // check vector on the no-pad instance
    sel = 1;
    @(negedge clk);
    s = "123456789";
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(s[i]);
    push_frame(7, 0, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("len_check", last_len, 21);
    expect_eq("fcs_b0", rx_q[17], 8'h26);
    expect_eq("fcs_b1", rx_q[18], 8'h39);
    expect_eq("fcs_b2", rx_q[19], 8'hF4);
    expect_eq("fcs_b3", rx_q[20], 8'hCB);
    repeat (15) @(negedge clk);

    // short frame padded to 60
    sel = 0;
    @(negedge clk);
    rand_pay(10);
    push_frame(7, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("len_pad", last_len, 72);
    repeat (15) @(negedge clk);

    // BADEOP
    rand_pay(64);
    d0 = done_cnt; e0 = err_cnt; r0 = er_cnt;
    push_frame(7, 60, 1'b1);
    send(1'b1, 0, 1'b0);
    wait_empty(3);
    expect_eq("bad_err", err_cnt - e0, 1);
    expect_eq("bad_done", done_cnt - d0, 0);
    expect_eq("bad_er_cycles", er_cnt - r0, 4);
    repeat (15) @(negedge clk);

    // underrun after byte 20, rest drained, then a normal frame
    rand_pay(64);
    e0 = err_cnt; r0 = er_cnt;
    push_head(7, 20);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    send(1'b0, 20, 1'b0);
    rand_pay(10);
    push_frame(7, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("ur_err", err_cnt - e0, 1);
    expect_eq("ur_er_cycles", er_cnt - r0, 1);
    expect_eq("ur_gap_min", last_gap >= 12, 1'b1);
    repeat (15) @(negedge clk);

    // back-to-back with short preamble and gap
    sel = 2;
    @(negedge clk);
    rand_pay(20);
    push_frame(3, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    rand_pay(20);
    push_frame(3, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("b2b_gap", last_gap, 5);
    expect_eq("b2b_len", last_len, 68);
    repeat (10) @(negedge clk);

    // SOP inside payload aborts, and that SOP opens the next frame
    rand_pay(8);
    e0 = err_cnt;
    push_head(3, 8);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    send(1'b0, 0, 1'b1);
    rand_pay(15);
    push_frame(3, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("sop_err", err_cnt - e0, 1);
    expect_eq("sop_gap", last_gap, 5);
    repeat (10) @(negedge clk);

    // reset mid-payload, then a clean frame
    rand_pay(40);
    sb_on = 1'b0;
    for (int i = 0; i < 12; i++) put(i == 0 ? PCC_SOP : PCC_DATA, pay[i]);
    expect_eq("mid_dv", dv_m, 1'b1);
    reset = 1'b1;
    srdy = 1'b0;
    @(negedge clk);
    expect_eq("rst_mid", {dv_m, er_m, done_m, err_m}, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    sb_on = 1'b1;
    @(negedge clk);
    rand_pay(20);
    push_frame(3, 60, 1'b0);
    send(1'b0, 0, 1'b0);
    wait_empty(3);
    expect_eq("post_rst_len", last_len, 68);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
